// File: rtl/message_stream_splitter_pkg.sv
// Framing shared by the message stream combiner and splitter so both ends agree on
// header layout, plus the splitter's parser state encoding.
package message_stream_splitter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DISCARD = 2'd2
    } split_state_t;

    // The header flag always sits in the word MSB, with the stream id directly below it.
    function automatic int hdr_flag_pos(input int wdth);
        return wdth - 1;
    endfunction

    function automatic int hdr_id_msb(input int wdth);
        return wdth - 2;
    endfunction

    function automatic logic [31:0] hdr_len_mask(input int len_width);
        return (32'd1 << len_width) - 32'd1;
    endfunction

endpackage

// File: rtl/message_header_decode.sv
// Combinational header field extraction and legality checks for one input word.
module message_header_decode
    import message_stream_splitter_pkg::*;
#(
    parameter int N_STREAMS         = 2,
    parameter int LOG_N_STREAMS     = 1,
    parameter int WDTH              = 32,
    parameter int MAX_PACKET_LENGTH = 127,
    parameter int MSG_LENGTH_WIDTH  = 7
) (
    input  logic [WDTH-1:0]             word,
    output logic                        is_header,
    output logic [LOG_N_STREAMS-1:0]    id,
    output logic [MSG_LENGTH_WIDTH-1:0] length,
    output logic                        id_ok,
    output logic                        length_ok
);

    localparam int FLAG_POS = hdr_flag_pos(WDTH);
    localparam int ID_MSB   = hdr_id_msb(WDTH);
    localparam logic [31:0] LEN_MASK = hdr_len_mask(MSG_LENGTH_WIDTH);

    logic [31:0] word_lsbs;
    logic        unused_word_bits;

    always_comb begin
        word_lsbs = '0;
        word_lsbs[MSG_LENGTH_WIDTH-1:0] = word[MSG_LENGTH_WIDTH-1:0];
    end

    assign is_header = word[FLAG_POS];
    assign id        = word[ID_MSB -: LOG_N_STREAMS];
    assign length    = MSG_LENGTH_WIDTH'(word_lsbs & LEN_MASK);

    // Id field may encode more values than there are streams (e.g. N=3 with a 2-bit id).
    assign id_ok     = 32'(id) < 32'(N_STREAMS);
    assign length_ok = 32'(length) <= 32'(MAX_PACKET_LENGTH);

    // Bits between the id field and the length field carry nothing for this parser.
    assign unused_word_bits = ^{word, word_lsbs};

endmodule

// File: rtl/message_stream_splitter.sv
// Demultiplexes a framed message stream (header + payload) onto per-stream outputs
// selected by the header's stream id; malformed headers pulse error.
//
//  state   | meaning
//  IDLE    | next valid word is parsed as a header
//  PAYLOAD | forwarding payload words to the latched stream
//  DISCARD | dropping payload of a rejected header
module message_stream_splitter
    import message_stream_splitter_pkg::*;
#(
    parameter int N_STREAMS         = 2,
    parameter int LOG_N_STREAMS     = 1,
    parameter int WDTH              = 32,
    parameter int MAX_PACKET_LENGTH = 127,
    parameter int MSG_LENGTH_WIDTH  = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WDTH-1:0]           in_data,
    input  logic                      in_nd,
    output logic [N_STREAMS*WDTH-1:0] out_data,
    output logic [N_STREAMS-1:0]      out_nd,
    output logic [N_STREAMS-1:0]      out_last,
    output logic                      error
);

    split_state_t                state;
    logic [MSG_LENGTH_WIDTH-1:0] remaining;
    logic [LOG_N_STREAMS-1:0]    cur_id;

    logic                        hdr_is_header;
    logic [LOG_N_STREAMS-1:0]    hdr_id;
    logic [MSG_LENGTH_WIDTH-1:0] hdr_length;
    logic                        hdr_id_ok;
    logic                        hdr_length_ok;
    logic                        last_word;

    message_header_decode #(
        .N_STREAMS         (N_STREAMS),
        .LOG_N_STREAMS     (LOG_N_STREAMS),
        .WDTH              (WDTH),
        .MAX_PACKET_LENGTH (MAX_PACKET_LENGTH),
        .MSG_LENGTH_WIDTH  (MSG_LENGTH_WIDTH)
    ) u_decode (
        .word      (in_data),
        .is_header (hdr_is_header),
        .id        (hdr_id),
        .length    (hdr_length),
        .id_ok     (hdr_id_ok),
        .length_ok (hdr_length_ok)
    );

    assign last_word = (remaining == MSG_LENGTH_WIDTH'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            cur_id    <= '0;
            out_data  <= '0;
            out_nd    <= '0;
            out_last  <= '0;
            error     <= 1'b0;
        end else begin
            out_nd   <= '0;
            out_last <= '0;
            error    <= 1'b0;
            if (in_nd) begin
                case (state)
                    IDLE: begin
                        if (!hdr_is_header) begin
                            error <= 1'b1;
                        end else if (!(hdr_id_ok && hdr_length_ok)) begin
                            // Still honour the length so we resync at the true packet boundary.
                            error <= 1'b1;
                            if (hdr_length != '0) begin
                                remaining <= hdr_length;
                                state     <= DISCARD;
                            end
                        end else if (hdr_length != '0) begin
                            cur_id    <= hdr_id;
                            remaining <= hdr_length;
                            state     <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        for (int k = 0; k < N_STREAMS; k++) begin
                            if (cur_id == LOG_N_STREAMS'(k)) begin
                                out_data[k*WDTH +: WDTH] <= in_data;
                                out_nd[k]                <= 1'b1;
                                out_last[k]              <= last_word;
                            end
                        end
                        remaining <= remaining - MSG_LENGTH_WIDTH'(1);
                        if (last_word) begin
                            state <= IDLE;
                        end
                    end
                    DISCARD: begin
                        remaining <= remaining - MSG_LENGTH_WIDTH'(1);
                        if (last_word) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
